// File: rtl/wb_stage.sv
// Writeback stage: picks the writeback source, formats loads, waits on UART RX
// bytes with a timeout, and drives the register-file write port and instret.
module wb_stage #(
    parameter int unsigned UART_TIMEOUT = 1024,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [4:0]       in_rd,
    input  logic             in_reg_write,
    input  logic [1:0]       in_wb_sel,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_pc_plus4,
    input  logic [31:0]      in_load_data,
    input  logic [2:0]       in_funct3,
    input  logic [1:0]       in_addr_lo,
    input  logic [7:0]       uart_rx_data,
    input  logic             uart_rx_valid,
    output logic             uart_rx_ack,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic             load_fault,
    output logic             uart_timeout,
    output logic [CNT_W-1:0] instret
);

    localparam int unsigned TW = (UART_TIMEOUT > 1) ? $clog2(UART_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLast = TW'(UART_TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StWaitUart} state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic [4:0]        rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              rf_we_d;
    logic [4:0]        rf_waddr_d;
    logic [31:0]       rf_wdata_d;
    logic              load_fault_d;
    logic              uart_timeout_d;
    logic [CNT_W-1:0]  instret_d;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic        ld_bad;
    logic [31:0] sel_val;
    logic        accept;

    // Load formatting from the raw aligned word.
    always_comb begin
        ld_val = 32'h0;
        ld_bad = 1'b0;
        unique case (in_addr_lo)
            2'd0:    ld_byte = in_load_data[7:0];
            2'd1:    ld_byte = in_load_data[15:8];
            2'd2:    ld_byte = in_load_data[23:16];
            default: ld_byte = in_load_data[31:24];
        endcase
        ld_half = in_addr_lo[1] ? in_load_data[31:16] : in_load_data[15:0];
        case (in_funct3)
            3'b000: ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_val = {24'h0, ld_byte};
            3'b001: begin
                ld_val = {{16{ld_half[15]}}, ld_half};
                ld_bad = in_addr_lo[0];
            end
            3'b101: begin
                ld_val = {16'h0, ld_half};
                ld_bad = in_addr_lo[0];
            end
            3'b010: begin
                ld_val = in_load_data;
                ld_bad = (in_addr_lo != 2'd0);
            end
            default: ld_bad = 1'b1;
        endcase
    end

    always_comb begin
        unique case (in_wb_sel)
            2'd1:    sel_val = ld_val;
            2'd2:    sel_val = in_pc_plus4;
            default: sel_val = in_alu_result;
        endcase
    end

    assign in_ready    = (state_q == StIdle) && !flush;
    assign uart_rx_ack = (state_q == StWaitUart) && uart_rx_valid && !flush;
    assign accept      = in_valid && in_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rd_d           = rd_q;
        rw_d           = rw_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr;
        rf_wdata_d     = rf_wdata;
        load_fault_d   = 1'b0;
        uart_timeout_d = 1'b0;
        instret_d      = instret;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (in_wb_sel == 2'd3) begin
                        state_d = StWaitUart;
                        rd_d    = in_rd;
                        rw_d    = in_reg_write;
                        cnt_d   = '0;
                    end else if (in_wb_sel == 2'd1 && ld_bad) begin
                        load_fault_d = 1'b1;
                    end else begin
                        rf_we_d   = in_reg_write && (in_rd != 5'd0);
                        instret_d = instret + CNT_W'(1);
                        if (rf_we_d) begin
                            rf_waddr_d = in_rd;
                            rf_wdata_d = sel_val;
                        end
                    end
                end
            end
            default: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (uart_rx_valid || cnt_q == TLast) begin
                    // A byte arriving on the expiry cycle still wins.
                    state_d        = StIdle;
                    uart_timeout_d = !uart_rx_valid;
                    rf_we_d        = rw_q && (rd_q != 5'd0);
                    instret_d      = instret + CNT_W'(1);
                    if (rf_we_d) begin
                        rf_waddr_d = rd_q;
                        rf_wdata_d = uart_rx_valid ? {24'h0, uart_rx_data} : 32'hFFFF_FFFF;
                    end
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rd_q         <= 5'd0;
            rw_q         <= 1'b0;
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            rf_wdata     <= 32'h0;
            load_fault   <= 1'b0;
            uart_timeout <= 1'b0;
            instret      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            rw_q         <= rw_d;
            rf_we        <= rf_we_d;
            rf_waddr     <= rf_waddr_d;
            rf_wdata     <= rf_wdata_d;
            load_fault   <= load_fault_d;
            uart_timeout <= uart_timeout_d;
            instret      <= instret_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with hand-computed expectations.
module tb_wb_stage;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, flush;
    logic [4:0]    in_rd;
    logic          in_reg_write;
    logic [1:0]    in_wb_sel;
    logic [31:0]   in_alu_result, in_pc_plus4, in_load_data;
    logic [2:0]    in_funct3;
    logic [1:0]    in_addr_lo;
    logic [7:0]    uart_rx_data;
    logic          uart_rx_valid, uart_rx_ack;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          load_fault, uart_timeout;
    logic [CW-1:0] instret;

    int total = 0;
    int bad   = 0;

    wb_stage #(.UART_TIMEOUT(8), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
        .in_load_data(in_load_data), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
        .uart_rx_ack(uart_rx_ack), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .load_fault(load_fault), .uart_timeout(uart_timeout), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one edge.
    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                         input logic [31:0] val, input logic [2:0] f3, input logic [1:0] off);
        in_valid      = 1'b1;
        in_wb_sel     = sel;
        in_rd         = rd;
        in_reg_write  = rw;
        in_alu_result = val;
        in_pc_plus4   = val;
        in_load_data  = val;
        in_funct3     = f3;
        in_addr_lo    = off;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; in_rd = 5'd0; in_reg_write = 1'b0;
        in_wb_sel = 2'd0; in_alu_result = 32'h0; in_pc_plus4 = 32'h0; in_load_data = 32'h0;
        in_funct3 = 3'd0; in_addr_lo = 2'd0; uart_rx_data = 8'h0; uart_rx_valid = 1'b0;
        step();
        check("rst_we", {31'h0, rf_we}, 32'h0);
        check("rst_wdata", rf_wdata, 32'h0);
        check("rst_instret", {28'h0, instret}, 32'h0);
        check("rst_ready", {31'h0, in_ready}, 32'h1);
        reset = 1'b0;
        step();

        issue(2'd0, 5'd5, 1'b1, 32'h1234, 3'd0, 2'd0);
        check("alu_we", {31'h0, rf_we}, 32'h1);
        check("alu_waddr", {27'h0, rf_waddr}, 32'd5);
        check("alu_wdata", rf_wdata, 32'h1234);
        check("alu_instret", {28'h0, instret}, 32'd1);
        step();
        check("idle_we", {31'h0, rf_we}, 32'h0);
        check("hold_wdata", rf_wdata, 32'h1234);

        // Back-to-back PC+4 then ALU.
        issue(2'd2, 5'd6, 1'b1, 32'h100, 3'd0, 2'd0);
        check("pc4_wdata", rf_wdata, 32'h100);
        issue(2'd0, 5'd7, 1'b1, 32'h55, 3'd0, 2'd0);
        check("b2b_we", {31'h0, rf_we}, 32'h1);
        check("b2b_wdata", rf_wdata, 32'h55);
        check("b2b_instret", {28'h0, instret}, 32'd3);

        issue(2'd1, 5'd8, 1'b1, 32'h80FF7F01, 3'b000, 2'd3);
        check("lb3", rf_wdata, 32'hFFFFFF80);
        issue(2'd1, 5'd8, 1'b1, 32'h80FF7F01, 3'b100, 2'd1);
        check("lbu1", rf_wdata, 32'h0000007F);
        issue(2'd1, 5'd8, 1'b1, 32'h80FF7F01, 3'b001, 2'd2);
        check("lh2", rf_wdata, 32'hFFFF80FF);
        check("lh_instret", {28'h0, instret}, 32'd6);
        issue(2'd1, 5'd9, 1'b1, 32'h80FF7F01, 3'b010, 2'd2);
        check("lw2_fault", {31'h0, load_fault}, 32'h1);
        check("lw2_we", {31'h0, rf_we}, 32'h0);
        check("lw2_instret", {28'h0, instret}, 32'd6);
        check("lw2_waddr_hold", {27'h0, rf_waddr}, 32'd8);
        issue(2'd1, 5'd9, 1'b1, 32'h80FF7F01, 3'b011, 2'd0);
        check("f3_011_fault", {31'h0, load_fault}, 32'h1);
        step();
        check("fault_pulse", {31'h0, load_fault}, 32'h0);

        issue(2'd0, 5'd0, 1'b1, 32'hDEAD, 3'd0, 2'd0);
        check("x0_we", {31'h0, rf_we}, 32'h0);
        check("x0_instret", {28'h0, instret}, 32'd7);

        // UART byte arrives four cycles after the accept.
        issue(2'd3, 5'd10, 1'b1, 32'h0, 3'd0, 2'd0);
        check("uart_nowrite", {31'h0, rf_we}, 32'h0);
        check("uart_ready", {31'h0, in_ready}, 32'h0);
        repeat (3) step();
        check("uart_noack", {31'h0, uart_rx_ack}, 32'h0);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h41;
        #1;
        check("uart_ack", {31'h0, uart_rx_ack}, 32'h1);
        step();
        uart_rx_valid = 1'b0;
        #1;
        check("uart_ack_once", {31'h0, uart_rx_ack}, 32'h0);
        check("uart_we", {31'h0, rf_we}, 32'h1);
        check("uart_waddr", {27'h0, rf_waddr}, 32'd10);
        check("uart_wdata", rf_wdata, 32'h00000041);
        check("uart_instret", {28'h0, instret}, 32'd8);
        check("uart_ready_back", {31'h0, in_ready}, 32'h1);

        // Timeout with no byte: expiry on the 8th waiting edge.
        issue(2'd3, 5'd11, 1'b1, 32'h0, 3'd0, 2'd0);
        repeat (7) step();
        check("to_early", {31'h0, uart_timeout}, 32'h0);
        check("to_early_ready", {31'h0, in_ready}, 32'h0);
        step();
        check("to_pulse", {31'h0, uart_timeout}, 32'h1);
        check("to_we", {31'h0, rf_we}, 32'h1);
        check("to_waddr", {27'h0, rf_waddr}, 32'd11);
        check("to_wdata", rf_wdata, 32'hFFFFFFFF);
        check("to_instret", {28'h0, instret}, 32'd9);
        step();
        check("to_pulse_end", {31'h0, uart_timeout}, 32'h0);

        // Byte on the expiry cycle wins.
        issue(2'd3, 5'd12, 1'b1, 32'h0, 3'd0, 2'd0);
        repeat (7) step();
        uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
        step();
        uart_rx_valid = 1'b0;
        check("race_timeout", {31'h0, uart_timeout}, 32'h0);
        check("race_wdata", rf_wdata, 32'h0000005A);
        check("race_instret", {28'h0, instret}, 32'd10);

        // Flush while waiting.
        issue(2'd3, 5'd13, 1'b1, 32'h0, 3'd0, 2'd0);
        repeat (2) step();
        flush = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'h77;
        #1;
        check("flush_noack", {31'h0, uart_rx_ack}, 32'h0);
        step();
        flush = 1'b0; uart_rx_valid = 1'b0;
        #1;
        check("flush_we", {31'h0, rf_we}, 32'h0);
        check("flush_instret", {28'h0, instret}, 32'd10);
        check("flush_idle", {31'h0, in_ready}, 32'h1);

        // Flush in IDLE blocks the accept.
        flush = 1'b1;
        #1;
        check("flush_ready", {31'h0, in_ready}, 32'h0);
        issue(2'd0, 5'd14, 1'b1, 32'hBEEF, 3'd0, 2'd0);
        flush = 1'b0;
        check("flush_idle_we", {31'h0, rf_we}, 32'h0);
        check("flush_idle_instret", {28'h0, instret}, 32'd10);

        // Asynchronous reset mid-wait, checked between edges.
        issue(2'd3, 5'd15, 1'b1, 32'h0, 3'd0, 2'd0);
        step();
        uart_rx_valid = 1'b1; uart_rx_data = 8'h33;
        #2 reset = 1'b1;
        #1;
        check("arst_wdata", rf_wdata, 32'h0);
        check("arst_waddr", {27'h0, rf_waddr}, 32'd0);
        check("arst_instret", {28'h0, instret}, 32'd0);
        check("arst_ack", {31'h0, uart_rx_ack}, 32'h0);
        #1 reset = 1'b0; uart_rx_valid = 1'b0;
        step();

        // instret wraps from all-ones to zero.
        for (int i = 0; i < 15; i++) issue(2'd0, 5'd1, 1'b1, i, 3'd0, 2'd0);
        check("wrap_full", {28'h0, instret}, 32'd15);
        issue(2'd0, 5'd1, 1'b1, 32'h0, 3'd0, 2'd0);
        check("wrap_zero", {28'h0, instret}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RISC-V core; sits directly upstream of the register file and drives its single write port (write enable, write address, write data).
- Accepts one completed instruction per handshake from the memory stage and selects the writeback source: ALU result, PC+4, formatted load data, or a byte from the UART RX buffer.
- UART reads are multi-cycle: the stage stalls until a byte arrives or a timeout expires.
- Also provides a retired-instruction counter and a load-fault pulse.

Parameters:
- UART_TIMEOUT, 1024, max cycles waited in WAIT_UART before giving up; must be >= 1.
- CNT_W, 32, width of instret counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- in_valid  input  1  memory stage presents an instruction.
- in_ready  output  1  stage can accept; = (state==IDLE) && !flush.
- flush  input  1  kill pending or arriving instruction.
- in_rd  input  5  destination register.
- in_reg_write  input  1  instruction writes rd.
- in_wb_sel  input  2  0 ALU, 1 load, 2 PC+4, 3 UART RX.
- in_alu_result  input  32  ALU result.
- in_pc_plus4  input  32  link value.
- in_load_data  input  32  raw aligned word from data memory.
- in_funct3  input  3  load type.
- in_addr_lo  input  2  byte offset of load address.
- uart_rx_data  input  8  UART received byte.
- uart_rx_valid  input  1  byte available.
- uart_rx_ack  output  1  combinational; = (state==WAIT_UART) && uart_rx_valid && !flush.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.
- load_fault  output  1  one-cycle pulse for a misaligned or illegal load.
- uart_timeout  output  1  one-cycle pulse when the UART wait expires.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (asynchronous): state=IDLE; rf_we, rf_waddr, rf_wdata, load_fault, uart_timeout = 0; instret = 0; timeout counter = 0.
- States: IDLE, WAIT_UART.
- Accept: in_valid && in_ready at a rising edge.
- Outputs registered; rf_we is never asserted for more than one cycle per instruction.
- Accept with sel 0/1/2, IDLE -> IDLE:
  - Next cycle rf_we = in_reg_write && (in_rd != 0), with rf_waddr=in_rd and rf_wdata=selected value.
  - instret increments at that same edge.
  - Back-to-back accepts are allowed: one writeback per cycle, throughput 1.
- Load formatting, using byte lane selected by addr_lo:
  - 000 LB: sign-extend byte lane addr_lo.
  - 100 LBU: zero-extend byte lane addr_lo.
  - 001 LH: sign-extend halfword lane addr_lo[1]; addr_lo[0]=1 is a fault.
  - 101 LHU: zero-extend halfword lane addr_lo[1]; addr_lo[0]=1 is a fault.
  - 010 LW: whole word; addr_lo != 0 is a fault.
  - Any other funct3 is a fault.
  - On fault: load_fault=1 next cycle, rf_we=0, instret unchanged.
- Accept with sel 3:
  - IDLE -> WAIT_UART; latch rd and reg_write; clear timeout counter; no write that cycle.
  - In WAIT_UART, with uart_rx_valid high: uart_rx_ack=1 that cycle; next cycle rf_we as above with rf_wdata={24'b0, uart_rx_data}; instret+1; -> IDLE.
  - In WAIT_UART with no byte: counter increments each cycle. When counter reaches UART_TIMEOUT-1 with no byte: next cycle uart_timeout=1, rf_we as latched with rf_wdata=32'hFFFFFFFF, instret+1, -> IDLE.
  - Byte and timeout in the same cycle: byte wins.
- Flush (has priority over every other event):
  - In IDLE: no accept (in_ready=0).
  - In WAIT_UART: -> IDLE with no write, no ack, no retire, no timeout pulse.
  - Does not cancel a writeback already registered at the preceding edge.
- rf_waddr/rf_wdata hold their last values when rf_we=0.
- instret wraps from all-ones to 0.
- Reset mid-WAIT_UART: immediately IDLE and outputs 0; the UART byte is not acked.

Test Plan:
- Reset, then accept sel=0, rd=5, alu=32'h1234, reg_write=1 -> next cycle rf_we=1, waddr=5, wdata=32'h1234, instret=1.
- Load word 32'h80FF7F01 with LB off 3 -> wdata 32'hFFFFFF80; LBU off 1 -> 32'h0000007F; LH off 2 -> 32'hFFFF80FF; LW off 2 -> load_fault=1, rf_we=0, instret unchanged.
- sel=3, rd=10; uart_rx_valid raised 4 cycles later with 8'h41 -> in_ready low while waiting, ack pulse once, next cycle wdata=32'h00000041, waddr=10.
- sel=3, UART_TIMEOUT=8, no byte -> uart_timeout pulse, wdata=32'hFFFFFFFF, instret+1; the byte-and-expiry-same-cycle case writes the byte.
- rd=0 with reg_write=1 -> rf_we stays 0, instret still increments; flush during WAIT_UART -> no write, no ack, returns IDLE.
- Assert reset asynchronously mid-WAIT_UART -> all outputs 0 without a clock edge; preload instret to all-ones, retire one -> instret=0.
